// File: rtl/dvp_sensor_tx.sv
// OV-style DVP transmitter: vsync/href/pclk with RGB565 pixels sent high byte first.
// Pixels come from an external show-ahead source or an internal test pattern.
module dvp_sensor_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK_B   = 288,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 18,
  parameter int V_FRONT     = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [1:0]  pattern_sel_i,
  input  logic [15:0] pix_i,
  output logic        pix_req_o,
  output logic        cmos_pclk_o,
  output logic        cmos_vsync_o,
  output logic        cmos_href_o,
  output logic [7:0]  cmos_data_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o
);
  localparam int LINE_B  = 2*H_ACTIVE + H_BLANK_B;
  localparam int FRAME_L = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int BCW     = $clog2(LINE_B);
  localparam int LNW     = $clog2(FRAME_L + 1);

  localparam logic [BCW-1:0] BC_LAST   = BCW'(LINE_B - 1);
  localparam logic [BCW-1:0] HREF_END  = BCW'(2*H_ACTIVE);
  localparam logic [LNW-1:0] L_VS_END  = LNW'(VSYNC_LINES - 1);
  localparam logic [LNW-1:0] L_VB_END  = LNW'(VSYNC_LINES + V_BACK - 1);
  localparam logic [LNW-1:0] L_ACT_END = LNW'(VSYNC_LINES + V_BACK + V_ACTIVE - 1);
  localparam logic [LNW-1:0] L_FR_END  = LNW'(FRAME_L - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t           r_state, w_nstate;
  logic             r_ph;
  logic [BCW-1:0]   r_bc, w_nbc;
  logic [LNW-1:0]   r_ln, w_nln, r_y, w_ny;
  logic             w_bstart, w_last, w_fstart, w_fdone;
  logic [1:0]       r_pat;
  logic [15:0]      r_solid, w_src, w_barpix;
  logic [7:0]       r_lo, w_ndata;
  logic             w_nhref, w_nvsync, w_nreq;
  logic [BCW-2:0]   w_x;
  logic [2:0]       w_bar;
  logic             r_req, r_vsync, r_href;
  logic [7:0]       r_data;
  logic [15:0]      r_fcnt;

  // IDLE treats every cycle as a byte boundary so a run request is taken immediately.
  assign w_bstart = (r_state == S_IDLE) | r_ph;
  assign w_last   = (r_bc == BC_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      r_state <= S_IDLE;
    else if (w_bstart) r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_nbc    = r_bc + 1'b1;
    w_nln    = r_ln;
    w_ny     = r_y;
    w_fstart = 1'b0;
    w_fdone  = 1'b0;
    if (r_state == S_IDLE) begin
      w_nbc = '0;
      w_nln = '0;
      w_ny  = '0;
      if (enable_i) begin
        w_nstate = S_VSYNC;
        w_fstart = 1'b1;
      end
    end else if (w_last) begin
      w_nbc = '0;
      w_nln = r_ln + 1'b1;
      if (r_state == S_ACTIVE) w_ny = r_y + 1'b1;
      case (r_state)
        S_VSYNC:  if (r_ln == L_VS_END)  w_nstate = S_VBACK;
        S_VBACK:  if (r_ln == L_VB_END)  w_nstate = S_ACTIVE;
        S_ACTIVE: if (r_ln == L_ACT_END) w_nstate = S_VFRONT;
        S_VFRONT: if (r_ln == L_FR_END) begin
          w_fdone  = 1'b1;
          w_nln    = '0;
          w_ny     = '0;
          w_nstate = enable_i ? S_VSYNC : S_IDLE;
          w_fstart = enable_i;
        end
        default: ;
      endcase
    end
  end

  // Everything below describes the byte that starts at the next byte boundary.
  always_comb begin
    w_nvsync = (w_nstate == S_VSYNC);
    w_nhref  = (w_nstate == S_ACTIVE) && (w_nbc < HREF_END);
    w_x      = w_nbc[BCW-1:1];
    w_bar    = 3'((32'(w_x) * 8) / H_ACTIVE);
    case (w_bar)
      3'd0:    w_barpix = 16'hFFFF;
      3'd1:    w_barpix = 16'hFFE0;
      3'd2:    w_barpix = 16'h07FF;
      3'd3:    w_barpix = 16'h07E0;
      3'd4:    w_barpix = 16'hF81F;
      3'd5:    w_barpix = 16'hF800;
      3'd6:    w_barpix = 16'h001F;
      default: w_barpix = 16'h0000;
    endcase
    case (r_pat)
      2'd0:    w_src = pix_i;
      2'd1:    w_src = w_barpix;
      2'd2:    w_src = {8'(w_ny), 8'(w_x)};
      default: w_src = r_solid;
    endcase
    w_ndata = 8'h00;
    if (w_nhref) w_ndata = w_nbc[0] ? r_lo : w_src[15:8];
    w_nreq = w_nhref && !w_nbc[0] && (r_pat == 2'd0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ph    <= 1'b0;
      r_bc    <= '0;
      r_ln    <= '0;
      r_y     <= '0;
      r_pat   <= 2'd0;
      r_solid <= 16'h0000;
      r_lo    <= 8'h00;
      r_req   <= 1'b0;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_data  <= 8'h00;
      r_fcnt  <= 16'h0000;
    end else begin
      r_ph  <= (r_state != S_IDLE) ? ~r_ph : 1'b0;
      // Strobe during the pclk-high half preceding an even byte; pix_i is taken at its start.
      r_req <= (r_state != S_IDLE) && !r_ph && w_nreq;
      if (w_bstart) begin
        r_bc    <= w_nbc;
        r_ln    <= w_nln;
        r_y     <= w_ny;
        r_vsync <= w_nvsync;
        r_href  <= w_nhref;
        r_data  <= w_ndata;
        if (w_nhref && !w_nbc[0]) r_lo <= w_src[7:0];
        if (w_fstart) begin
          r_pat   <= pattern_sel_i;
          r_solid <= pix_i;
        end
        if (w_fdone) r_fcnt <= r_fcnt + 16'd1;
      end
    end
  end

  assign pix_req_o    = r_req;
  assign cmos_pclk_o  = r_ph;
  assign cmos_vsync_o = r_vsync;
  assign cmos_href_o  = r_href;
  assign cmos_data_o  = r_data;
  assign busy_o       = (r_state != S_IDLE);
  assign frame_cnt_o  = r_fcnt;
endmodule

// File: tb/tb_dvp_sensor_tx.sv
// Bench for dvp_sensor_tx with small frame geometry (40 clk per line, 280 clk per frame).
// Expected bytes are queued ahead of time; a monitor pops one per pclk-high half inside href.
module tb_dvp_sensor_tx;
  logic        clk, rst_n, enable, use_ext;
  logic [1:0]  pattern_sel;
  logic [15:0] ext_pix, man_pix, pix;
  logic        pix_req, pclk, vsync, href, busy;
  logic [7:0]  data;
  logic [15:0] frame_cnt;

  int n_chk = 0, n_err = 0;
  int cyc = 0, t0 = 0;
  int href_rises = 0, vsync_rises = 0, n_req = 0, blank_bad = 0;
  logic prev_href = 1'b0, prev_vsync = 1'b0;
  logic [7:0] exp_q[$];
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  assign pix = use_ext ? ext_pix : man_pix;

  dvp_sensor_tx #(.H_ACTIVE(8), .H_BLANK_B(4), .V_ACTIVE(4),
                  .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .pattern_sel_i(pattern_sel),
    .pix_i(pix), .pix_req_o(pix_req), .cmos_pclk_o(pclk), .cmos_vsync_o(vsync),
    .cmos_href_o(href), .cmos_data_o(data), .busy_o(busy), .frame_cnt_o(frame_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic at(input int k);
    int n;
    n = t0 + k - cyc;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pix(input logic [15:0] p);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
  endtask

  // Scoreboard monitor: one byte per pclk-high half while href is up.
  initial forever begin
    @(negedge clk);
    if (pclk && href) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL byte_unexpected act=%0h exp=none", data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          n_err++;
          $display("FAIL byte act=%0h exp=%0h", data, e);
        end
      end
    end
    if (!href && data != 8'h00) blank_bad++;
    if (href && !prev_href) href_rises++;
    if (vsync && !prev_vsync) vsync_rises++;
    prev_href  = href;
    prev_vsync = vsync;
  end

  // External show-ahead source: value on pix_i is consumed at the edge after a strobe.
  initial begin
    ext_pix = 16'hA500;
    forever begin
      @(negedge clk);
      if (pix_req) begin
        n_req++;
        push_pix(ext_pix);
        @(posedge clk);
        #1 ext_pix = ext_pix + 16'd1;
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd1; use_ext = 1'b1; man_pix = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pclk", pclk, 0);   chk("rst_vsync", vsync, 0); chk("rst_href", href, 0);
    chk("rst_data", data, 0);   chk("rst_busy", busy, 0);   chk("rst_req", pix_req, 0);
    chk("rst_fcnt", frame_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_pclk", pclk, 0); chk("idle_busy", busy, 0);

    // Frame 1: colour bars, timing checks
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) push_pix(bars[x]);
    @(negedge clk) enable = 1'b1;
    @(posedge clk); #1; t0 = cyc; href_rises = 0;
    chk("f1_busy0", busy, 1); chk("f1_vsync0", vsync, 1); chk("f1_pclk0", pclk, 0);
    at(1);   chk("f1_pclk_rise", pclk, 1);
    at(39);  chk("f1_vsync39", vsync, 1);
    at(40);  chk("f1_vsync40", vsync, 0);
    at(79);  chk("f1_href79", href, 0);
    at(80);  chk("f1_href80", href, 1); chk("f1_data80", data, 8'hFF);
    at(111); chk("f1_href111", href, 1);
    at(112); chk("f1_href112", href, 0); chk("f1_blank112", data, 0);
    at(150);
    pattern_sel = 2'd2;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) push_pix({8'(y), 8'(x)});
    at(279); chk("f1_fcnt279", frame_cnt, 0);
    at(280); chk("f1_fcnt280", frame_cnt, 1); chk("f1_href_pulses", href_rises, 4);
    chk("f2_vsync0", vsync, 1); chk("f2_busy0", busy, 1);
    t0 = cyc;

    // Frame 2: x/y counter pattern; then external source for frame 3
    at(150); pattern_sel = 2'd0;
    chk("f2_no_req", n_req, 0);
    at(280); chk("f2_fcnt", frame_cnt, 2);
    t0 = cyc;

    // Frame 3: external pixels, enable dropped mid-frame
    at(100); enable = 1'b0;
    at(115); chk("f3_req_line0", n_req, 8);
    at(279); chk("f3_busy279", busy, 1);
    at(280); chk("f3_busy280", busy, 0); chk("f3_fcnt", frame_cnt, 3);
    chk("f3_pclk_idle", pclk, 0); chk("f3_req_frame", n_req, 32);
    at(380); chk("idle_pclk_low", pclk, 0); chk("idle_vsync", vsync, 0);
    chk("idle_no_new_vsync", vsync_rises, 3); chk("idle_fcnt", frame_cnt, 3);

    // Reset in the middle of href, then a clean solid-colour frame
    use_ext = 1'b0; pattern_sel = 2'd1;
    for (int x = 0; x < 8; x++) push_pix(bars[x]);
    @(negedge clk) enable = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    at(97); chk("r_href_before", href, 1);
    rst_n = 1'b0;
    #1;
    chk("r_pclk", pclk, 0); chk("r_vsync", vsync, 0); chk("r_href", href, 0);
    chk("r_data", data, 0); chk("r_busy", busy, 0);   chk("r_fcnt", frame_cnt, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    pattern_sel = 2'd3; man_pix = 16'h5AC3;
    for (int i = 0; i < 32; i++) push_pix(16'h5AC3);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    man_pix = 16'h1111;
    chk("s_vsync0", vsync, 1); chk("s_busy0", busy, 1); chk("s_fcnt0", frame_cnt, 0);
    at(100); enable = 1'b0;
    at(280); chk("s_fcnt", frame_cnt, 1); chk("s_busy", busy, 0);
    at(300);
    chk("queue_drained", exp_q.size(), 0);
    chk("blank_data_zero", blank_bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
